alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same 4-bit function-select encoding and Z/C/N/O flag layout, generalised to WIDTH bits. Results and flags are registered, and shifts/rotates become multi-cycle shift-by-N operations. It sits between the register file/operand muxes and the writeback path, behind a valid/ready handshake on both sides.

---
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operation request side and result side.
// The slave modport is the ALU; the master modport is the issuing/consuming logic.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       fun_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             flag_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_alu;
  logic [3:0]       flags;

  modport master (
    output in_valid, fun_sel, a, b, shamt, flag_clr, out_ready,
    input  in_ready, out_valid, out_alu, flags
  );

  modport slave (
    input  in_valid, fun_sel, a, b, shamt, flag_clr, out_ready,
    output in_ready, out_valid, out_alu, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with multi-cycle shift/rotate-by-N.
// Flags are {Z,C,N,O} on bits [3:0].
// Optional feature: define ALU_PIPE_SAT_EN to saturate add/sub on signed overflow;
// left undefined, add/sub results wrap modulo 2^WIDTH.
module alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] OpA   = 4'b0000;
  localparam logic [3:0] OpB   = 4'b0001;
  localparam logic [3:0] OpNa  = 4'b0010;
  localparam logic [3:0] OpNb  = 4'b0011;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpSub = 4'b0101;
  localparam logic [3:0] OpCmp = 4'b0110;
  localparam logic [3:0] OpAnd = 4'b0111;
  localparam logic [3:0] OpOr  = 4'b1000;
  localparam logic [3:0] OpNnd = 4'b1001;
  localparam logic [3:0] OpXor = 4'b1010;
  localparam logic [3:0] OpLsl = 4'b1011;
  localparam logic [3:0] OpLsr = 4'b1100;
  localparam logic [3:0] OpAsl = 4'b1101;
  localparam logic [3:0] OpAsr = 4'b1110;
  localparam logic [3:0] OpCsr = 4'b1111;

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             wc_q, wc_d;     // working carry for shifts/rotate
  logic             wo_q, wo_d;     // sticky sign-change for ASL
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] out_alu_q, out_alu_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic             is_shift;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o, alu_wc, alu_wo;

  logic [WIDTH-1:0] step_w;
  logic             step_c, step_o;

  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_o, fin_wc, fin_wo;
  logic [3:0]       flags_fin;

  assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_shift = (bus.fun_sel >= OpLsl);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_alu   = out_alu_q;
  assign bus.flags     = flags_q;

  // Single-cycle datapath; shift codes fall to the default (shamt=0 passes a).
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, flags_q[2]};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res = bus.a;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_wc  = 1'b0;
    alu_wo  = 1'b0;
    case (bus.fun_sel)
      OpA:  alu_res = bus.a;
      OpB:  alu_res = bus.b;
      OpNa: alu_res = ~bus.a;
      OpNb: alu_res = ~bus.b;
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        alu_wc  = 1'b1;
        alu_wo  = 1'b1;
`ifdef ALU_PIPE_SAT_EN
        if (alu_o) alu_res = bus.a[WIDTH-1] ? SatMin : SatMax;
`endif
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_o   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
        alu_wc  = 1'b1;
        alu_wo  = 1'b1;
`ifdef ALU_PIPE_SAT_EN
        if (alu_o) alu_res = bus.a[WIDTH-1] ? SatMin : SatMax;
`endif
      end
      OpCmp: begin
        alu_res = diff[WIDTH] ? bus.a : '0;
        alu_c   = diff[WIDTH];
        alu_wc  = 1'b1;
      end
      OpAnd: alu_res = bus.a & bus.b;
      OpOr:  alu_res = bus.a | bus.b;
      OpNnd: alu_res = ~(bus.a & bus.b);
      OpXor: alu_res = bus.a ^ bus.b;
      default: alu_res = bus.a;
    endcase
  end

  // One single-bit step of the latched shift/rotate op on the working register.
  always_comb begin
    step_w = work_q;
    step_c = wc_q;
    step_o = wo_q;
    case (op_q)
      OpLsl: begin
        step_c = work_q[WIDTH-1];
        step_w = {work_q[WIDTH-2:0], 1'b0};
      end
      OpLsr: begin
        step_c = work_q[0];
        step_w = {1'b0, work_q[WIDTH-1:1]};
      end
      OpAsl: begin
        step_w = {work_q[WIDTH-2:0], 1'b0};
        step_o = wo_q | (work_q[WIDTH-1] ^ work_q[WIDTH-2]);
      end
      OpAsr: step_w = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OpCsr: begin
        step_w = {wc_q, work_q[WIDTH-1:1]};
        step_c = work_q[0];
      end
      default: step_w = work_q;
    endcase
  end

  // Flags as they would be written if an op completes at this edge.
  always_comb begin
    if (state_q == StShift) begin
      fin_res = step_w;
      fin_c   = step_c;
      fin_o   = step_o;
      fin_wc  = op_q inside {OpLsl, OpLsr, OpCsr};
      fin_wo  = (op_q == OpAsl);
    end else begin
      fin_res = alu_res;
      fin_c   = alu_c;
      fin_o   = alu_o;
      fin_wc  = alu_wc;
      fin_wo  = alu_wo;
    end
    // Clear applies first so completion values win only on the bits the op owns.
    flags_fin    = bus.flag_clr ? 4'b0000 : flags_q;
    flags_fin[3] = (fin_res == '0);
    flags_fin[1] = fin_res[WIDTH-1];
    if (fin_wc) flags_fin[2] = fin_c;
    if (fin_wo) flags_fin[0] = fin_o;
  end

  // Next-state: accept/complete in IDLE, step and count down in SHIFT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    wc_d        = wc_q;
    wo_d        = wo_q;
    op_d        = op_q;
    out_alu_d   = out_alu_q;
    out_valid_d = out_valid_q;
    flags_d     = bus.flag_clr ? 4'b0000 : flags_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift && (bus.shamt != '0)) begin
            state_d = StShift;
            cnt_d   = bus.shamt;
            work_d  = bus.a;
            wc_d    = flags_q[2];
            wo_d    = 1'b0;
            op_d    = bus.fun_sel;
          end else begin
            out_alu_d   = alu_res;
            out_valid_d = 1'b1;
            flags_d     = flags_fin;
          end
        end
      end
      StShift: begin
        work_d = step_w;
        wc_d   = step_c;
        wo_d   = step_o;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d     = StIdle;
          out_alu_d   = step_w;
          out_valid_d = 1'b1;
          flags_d     = flags_fin;
        end
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      work_q      <= '0;
      wc_q        <= 1'b0;
      wo_q        <= 1'b0;
      op_q        <= 4'b0000;
      out_alu_q   <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      wc_q        <= wc_d;
      wo_q        <= wo_d;
      op_q        <= op_d;
      out_alu_q   <= out_alu_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed scenarios plus randomized ops,
// expected results from an arithmetic reference model held in the bench.
module tb_alu_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  logic rst_n;

  alu_pipe_if #(.WIDTH(W), .SHW(SW)) bus ();

  alu_pipe #(.WIDTH(W), .SHW(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [3:0]  mflags;
  logic [11:0] exp_q[$];
  logic [7:0]  last_res;
  logic [3:0]  last_fl;
  int          last_wait;
  bit          rand_rdy = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model: acts on the op as a whole, updates model flags.
  function automatic void model(input int f, input int ai, input int bi, input int sh,
                                input bit clr, output int res, output logic [3:0] fl);
    int  cin, c, o, s, v, t, ao;
    bit  wc, wo;
    cin = int'(mflags[2]);
    c = cin; o = int'(mflags[0]); wc = 1'b0; wo = 1'b0; res = 0;
    case (f)
      0: res = ai;
      1: res = bi;
      2: res = 255 - ai;
      3: res = 255 - bi;
      4: begin
        res = (ai + bi + cin) % 256;
        c   = (ai + bi + cin > 255) ? 1 : 0;
        s   = sgn(ai) + sgn(bi) + cin;
        o   = (s > 127 || s < -128) ? 1 : 0;
        wc = 1'b1; wo = 1'b1;
`ifdef ALU_PIPE_SAT_EN
        if (o == 1) res = (s > 127) ? 127 : 128;
`endif
      end
      5: begin
        res = (ai - bi + 256) % 256;
        c   = (ai < bi) ? 1 : 0;
        s   = sgn(ai) - sgn(bi);
        o   = (s > 127 || s < -128) ? 1 : 0;
        wc = 1'b1; wo = 1'b1;
`ifdef ALU_PIPE_SAT_EN
        if (o == 1) res = (s > 127) ? 127 : 128;
`endif
      end
      6: begin
        res = (ai < bi) ? ai : 0;
        c   = (ai < bi) ? 1 : 0;
        wc  = 1'b1;
      end
      7:  res = ai & bi;
      8:  res = ai | bi;
      9:  res = 255 - (ai & bi);
      10: res = ai ^ bi;
      default: begin
        v  = ai;
        ao = 0;
        for (int k = 0; k < sh; k++) begin
          case (f)
            11: begin c = (v >> 7) & 1; v = (v * 2) % 256; end
            12: begin c = v & 1; v = v / 2; end
            13: begin t = (v >> 7) & 1; v = (v * 2) % 256; if (((v >> 7) & 1) != t) ao = 1; end
            14: v = (v / 2) | (v & 128);
            default: begin t = v & 1; v = (v / 2) | (c * 128); c = t; end
          endcase
        end
        res = v;
        wc  = (sh > 0) && (f == 11 || f == 12 || f == 15);
        wo  = (sh > 0) && (f == 13);
        o   = ao;
      end
    endcase
    fl    = clr ? 4'b0000 : mflags;
    fl[3] = (res == 0);
    fl[1] = (res >= 128);
    if (wc) fl[2] = c[0];
    if (wo) fl[0] = o[0];
    mflags = fl;
  endfunction

  // Offer one op from posedge+1; push the expected result at the accepting cycle.
  task automatic issue(input logic [3:0] f, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [2:0] sh, input bit clr);
    int         n;
    int         res;
    logic [3:0] fl;
    n = 0;
    bus.in_valid = 1'b1; bus.fun_sel = f; bus.a = ai; bus.b = bi;
    bus.shamt = sh; bus.flag_clr = clr;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      model(int'(f), int'(ai), int'(bi), int'(sh), clr, res, fl);
      last_res = 8'(res);
      last_fl  = fl;
      exp_q.push_back({8'(res), fl});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flag_clr = 1'b0;
  endtask

  // Monitor: every consumed result is compared against the oldest expectation.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", int'({bus.out_alu, bus.flags}), int'(e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.fun_sel = 4'h0; bus.a = 8'h00; bus.b = 8'h00;
    bus.shamt = 3'd0; bus.flag_clr = 1'b0; bus.out_ready = 1'b1;
    mflags = 4'b0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_flags", int'(bus.flags), 0);
    check("rst_out_alu", int'(bus.out_alu), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", int'(bus.in_ready), 1);

    // Signed-overflow add, C=0.
    issue(4'b0100, 8'h7F, 8'h01, 3'd0, 1'b0);
    check("add_ovf_valid", int'(bus.out_valid), 1);
`ifdef ALU_PIPE_SAT_EN
    check("add_ovf_out", int'(bus.out_alu), 'h7F);
    check("add_ovf_flags", int'(bus.flags), 'b0001);
`else
    check("add_ovf_out", int'(bus.out_alu), 'h80);
    check("add_ovf_flags", int'(bus.flags), 'b0011);
`endif

    // Back-to-back adds: carry from the first feeds the second.
    issue(4'b0100, 8'hFF, 8'h01, 3'd0, 1'b0);
    check("b2b1_wait", last_wait, 0);
    check("b2b1_out", int'(bus.out_alu), 'h00);
    check("b2b1_flags", int'(bus.flags), 'b1100);
    issue(4'b0100, 8'h00, 8'h00, 3'd0, 1'b0);
    check("b2b2_wait", last_wait, 0);
    check("b2b2_out", int'(bus.out_alu), 'h01);
    check("b2b2_flags", int'(bus.flags), 'b0000);

    // LSL by 3: busy for the intermediate cycles.
    issue(4'b1011, 8'h31, 8'h00, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("lsl_busy_valid", int'(bus.out_valid), 0);
      check("lsl_busy_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    check("lsl_valid", int'(bus.out_valid), 1);
    check("lsl_out", int'(bus.out_alu), 'h88);
    check("lsl_flags", int'(bus.flags), 'b0110);

    // Stalled consumer: result holds, no new op accepted.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'b1010, 8'h3C, 8'h0F, 3'd0, 1'b0);
    bus.in_valid = 1'b1; bus.fun_sel = 4'b0111; bus.a = 8'hF0; bus.b = 8'h3C; bus.shamt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(bus.in_ready), 0);
      check("stall_out", int'(bus.out_alu), int'(last_res));
      check("stall_flags", int'(bus.flags), int'(last_fl));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(4'b0111, 8'hF0, 8'h3C, 3'd0, 1'b0);
    check("stall_release_wait", last_wait, 0);
    check("stall_next_valid", int'(bus.out_valid), 1);
    check("stall_next_out", int'(bus.out_alu), 'h30);

    // Reset in the middle of a rotate.
    @(posedge clk); #1;
    issue(4'b1111, 8'hA5, 8'h00, 3'd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(bus.out_valid), 0);
    check("midrst_flags", int'(bus.flags), 0);
    check("midrst_out", int'(bus.out_alu), 0);
    exp_q.delete();
    mflags = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      check("midrst_no_valid", int'(bus.out_valid), 0);
    end
    issue(4'b0110, 8'h10, 8'h20, 3'd0, 1'b0);
    check("cmp_out", int'(bus.out_alu), 'h10);
    check("cmp_flags", int'(bus.flags), 'b0100);

    // flag_clr while idle, then coincident with a completion.
    issue(4'b0100, 8'h80, 8'h80, 3'd0, 1'b0);
    check("pre_clr_flags", int'(bus.flags), int'(last_fl));
    bus.flag_clr = 1'b1;
    @(posedge clk); #1;
    bus.flag_clr = 1'b0;
    mflags = 4'b0000;
    check("idle_clr_flags", int'(bus.flags), 0);
    issue(4'b0100, 8'h80, 8'h80, 3'd0, 1'b0);
    issue(4'b1010, 8'h0F, 8'h0F, 3'd0, 1'b1);
    check("clr_xor_out", int'(bus.out_alu), 'h00);
    check("clr_xor_flags", int'(bus.flags), 'b1000);

    // Randomized ops with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)), 1'b0);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
